// File: rtl/key_event_arbiter.sv
// key_event_arbiter: queues one-cycle key press pulses in per-key saturating
// counters and serialises them onto one valid/ready event port using
// round-robin arbitration.
// Optional feature macro: EVT_TIMEOUT_EN. When it is defined, an event that
// is not accepted within TIMEOUT_CYC cycles is dropped and evt_drop pulses.
module key_event_arbiter #(
  parameter int unsigned N_KEYS      = 3,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] press,
  input  logic              ovf_clr,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [ID_W-1:0]   evt_id,
  output logic [N_KEYS-1:0] pending,
  output logic [N_KEYS-1:0] ovf,
  output logic              busy,
  output logic              evt_drop
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARB     = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt    [N_KEYS];
  logic [CNT_W-1:0]    cnt_nx [N_KEYS];
  logic [N_KEYS-1:0]   nz;
  logic [N_KEYS-1:0]   dec;
  logic [N_KEYS-1:0]   ovf_nx;
  logic [N_KEYS-1:0]   pending_nx;
  logic [ID_W-1:0]     last_grant, last_grant_nx;
  logic [ID_W-1:0]     evt_id_nx;
  logic [ID_W-1:0]     winner, win_hi, win_lo;
  logic                found_hi;
  logic                evt_valid_nx;

`ifdef EVT_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall, stall_nx;
  logic               drop_nx;
`else
  // The stall limit has no effect without the timer; referenced here so the
  // parameter list stays identical in both builds.
  if (TIMEOUT_CYC == 0) begin : g_timeout_unused
  end
`endif

  // Nonzero flags of the current counters feed both IDLE wake-up and the search.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      nz[i] = (cnt[i] != '0);
    end
  end

  // Round-robin search: lowest nonzero key above last_grant, else lowest nonzero key.
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (nz[i]) begin
        win_lo = ID_W'(i);
        if (i > int'(last_grant)) begin
          win_hi   = ID_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

  // Next-state and registered-output values of the event FSM.
  always_comb begin
    state_nx      = state;
    evt_valid_nx  = evt_valid;
    evt_id_nx     = evt_id;
    last_grant_nx = last_grant;
    dec           = '0;
`ifdef EVT_TIMEOUT_EN
    stall_nx      = stall;
    drop_nx       = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (|nz) begin
          state_nx = S_ARB;
        end
      end
      S_ARB: begin
        evt_id_nx     = winner;
        evt_valid_nx  = 1'b1;
        last_grant_nx = winner;
        dec           = N_KEYS'(1) << winner;
        state_nx      = S_PRESENT;
`ifdef EVT_TIMEOUT_EN
        stall_nx      = '0;
`endif
      end
      S_PRESENT: begin
        if (evt_valid && evt_ready) begin
          evt_valid_nx = 1'b0;
          state_nx     = S_IDLE;
        end
`ifdef EVT_TIMEOUT_EN
        else if (stall == STALL_W'(TIMEOUT_CYC - 1)) begin
          evt_valid_nx = 1'b0;
          drop_nx      = 1'b1;
          state_nx     = S_IDLE;
        end else begin
          stall_nx = stall + STALL_W'(1);
        end
`endif
      end
      default: begin
        evt_valid_nx = 1'b0;
        state_nx     = S_IDLE;
      end
    endcase
  end

  // Per-key counter arithmetic: +press -grant, saturating, with sticky overflow.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      cnt_nx[i] = cnt[i];
      ovf_nx[i] = ovf[i] & ~ovf_clr;
      if (press[i] && !dec[i]) begin
        if (cnt[i] == CNT_MAX) begin
          ovf_nx[i] = 1'b1;
        end else begin
          cnt_nx[i] = cnt[i] + CNT_W'(1);
        end
      end else if (!press[i] && dec[i]) begin
        cnt_nx[i] = cnt[i] - CNT_W'(1);
      end
      pending_nx[i] = (cnt_nx[i] != '0);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= ID_W'(N_KEYS - 1);
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      pending    <= '0;
      ovf        <= '0;
      busy       <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      evt_valid  <= evt_valid_nx;
      evt_id     <= evt_id_nx;
      pending    <= pending_nx;
      ovf        <= ovf_nx;
      busy       <= (state_nx != S_IDLE);
      for (int i = 0; i < N_KEYS; i++) begin
        cnt[i] <= cnt_nx[i];
      end
    end
  end

`ifdef EVT_TIMEOUT_EN
  // Stall timer and drop pulse for unaccepted events.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall    <= '0;
      evt_drop <= 1'b0;
    end else begin
      stall    <= stall_nx;
      evt_drop <= drop_nx;
    end
  end
`else
  assign evt_drop = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_arbiter.sv
// Self-checking bench for key_event_arbiter: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_key_event_arbiter;

  localparam int N    = 3;
  localparam int MAXC = 15;
  localparam int TO   = 8;
`ifdef EVT_TIMEOUT_EN
  localparam int HOLD = 5;
`else
  localparam int HOLD = 10;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] press;
  logic       ovf_clr;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [2:0] pending;
  logic [2:0] ovf;
  logic       busy;
  logic       evt_drop;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_cnt [N];
  bit m_ovf [N];
  bit m_valid, m_armed, m_drop;
  int m_id, m_last, m_stall;
  int m_log[$];
  int d_log[$];

  key_event_arbiter #(.N_KEYS(3), .CNT_W(4), .ID_W(2), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .press(press), .ovf_clr(ovf_clr),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .pending(pending), .ovf(ovf), .busy(busy), .evt_drop(evt_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock of the spec behaviour: arbitration waits one idle cycle, then
  // the round-robin winner is presented until accepted (or timed out).
  function automatic void model_step(input logic [2:0] p, input logic r,
                                     input logic c, input logic rs);
    int  dk;
    bit  any;
    bit  set;
    if (rs) begin
      for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_ovf[i] = 0; end
      m_valid = 0; m_armed = 0; m_drop = 0; m_id = 0; m_last = N - 1; m_stall = 0;
      return;
    end
    dk = -1; any = 0; m_drop = 0;
    for (int i = 0; i < N; i++) if (m_cnt[i] != 0) any = 1;
    if (m_valid) begin
      if (r) begin
        m_log.push_back(m_id);
        m_valid = 0;
      end
`ifdef EVT_TIMEOUT_EN
      else if (m_stall + 1 == TO) begin
        m_valid = 0;
        m_drop  = 1;
      end else begin
        m_stall++;
      end
`endif
    end else if (m_armed) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (dk < 0 && m_cnt[j] != 0) dk = j;
      end
      m_id = dk; m_last = dk; m_valid = 1; m_armed = 0; m_stall = 0;
    end else if (any) begin
      m_armed = 1;
    end
    for (int i = 0; i < N; i++) begin
      set = 0;
      if (p[i] && i != dk) begin
        if (m_cnt[i] == MAXC) set = 1;
        else m_cnt[i]++;
      end else if (!p[i] && i == dk) begin
        m_cnt[i]--;
      end
      m_ovf[i] = set || (m_ovf[i] && !c);
    end
  endfunction

  function automatic logic [2:0] m_pending_vec();
    logic [2:0] v;
    for (int i = 0; i < N; i++) v[i] = (m_cnt[i] != 0);
    return v;
  endfunction

  function automatic logic [2:0] m_ovf_vec();
    logic [2:0] v;
    for (int i = 0; i < N; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  // Drive one cycle of inputs, log any handshake, advance the model.
  task automatic tick(input logic [2:0] p, input logic r, input logic c, input logic rs);
    press = p; evt_ready = r; ovf_clr = c; rst = rs;
    if (!rs && evt_valid === 1'b1 && r) d_log.push_back(int'(evt_id));
    @(posedge clk);
    model_step(p, r, c, rs);
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick(3'b000, 1'b0, 1'b0, 1'b1);
    d_log.delete();
    m_log.delete();
  endtask

  task automatic test_reset();
    tick(3'b111, 1'b1, 1'b0, 1'b1);
    tick(3'b000, 1'b0, 1'b0, 1'b1);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
    checks++; if (evt_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", evt_id); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL reset_pending got=%b exp=000", pending); end
    checks++; if (ovf !== 3'b000) begin errors++; $display("FAIL reset_ovf got=%b exp=000", ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (evt_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", evt_drop); end
    d_log.delete();
    m_log.delete();
  endtask

  task automatic test_single_press();
    do_reset();
    tick(3'b010, 1'b1, 1'b0, 1'b0);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_e0_valid got=%b exp=0", evt_valid); end
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL single_e0_pending got=%b exp=010", pending); end
    tick(3'b000, 1'b1, 1'b0, 1'b0);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_e1_valid got=%b exp=0", evt_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_e1_busy got=%b exp=1", busy); end
    tick(3'b000, 1'b1, 1'b0, 1'b0);
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL single_e2_valid got=%b exp=1", evt_valid); end
    checks++; if (evt_id !== 2'd1) begin errors++; $display("FAIL single_e2_id got=%0d exp=1", evt_id); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL single_e2_pending got=%b exp=000", pending); end
    tick(3'b000, 1'b1, 1'b0, 1'b0);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_e3_valid got=%b exp=0", evt_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_e3_busy got=%b exp=0", busy); end
    checks++; if (d_log.size() != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", d_log.size()); end
  endtask

  task automatic test_all_keys();
    int exp_seq[3] = '{0, 1, 2};
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      d_log.delete();
      tick(3'b111, 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 12; c++) tick(3'b000, 1'b1, 1'b0, 1'b0);
      checks++;
      if (d_log.size() != 3) begin errors++; $display("FAIL all_keys_count rep=%0d got=%0d exp=3", rep, d_log.size()); end
      for (int k = 0; k < 3 && k < d_log.size(); k++) begin
        checks++;
        if (d_log[k] != exp_seq[k]) begin errors++; $display("FAIL all_keys_order rep=%0d idx=%0d got=%0d exp=%0d", rep, k, d_log[k], exp_seq[k]); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL all_keys_busy got=%b exp=0", busy); end
    end
  endtask

  task automatic test_burst_order();
    int exp_seq[4] = '{0, 2, 0, 0};
    do_reset();
    tick(3'b001, 1'b1, 1'b0, 1'b0);
    tick(3'b001, 1'b1, 1'b0, 1'b0);
    tick(3'b101, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 16; c++) tick(3'b000, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_log.size() != 4) begin errors++; $display("FAIL burst_count got=%0d exp=4", d_log.size()); end
    for (int k = 0; k < 4 && k < d_log.size(); k++) begin
      checks++;
      if (d_log[k] != exp_seq[k]) begin errors++; $display("FAIL burst_order idx=%0d got=%0d exp=%0d", k, d_log[k], exp_seq[k]); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 17; k++) begin
      tick(3'b001, 1'b0, 1'b0, 1'b0);
      tick(3'b000, 1'b0, 1'b0, 1'b0);
      checks++;
      if (ovf !== m_ovf_vec()) begin errors++; $display("FAIL sat_ovf_model press=%0d got=%b exp=%b", k + 1, ovf, m_ovf_vec()); end
`ifndef EVT_TIMEOUT_EN
      if (k >= 1) begin
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
          errors++; $display("FAIL sat_hold press=%0d got valid=%b id=%0d exp valid=1 id=0", k + 1, evt_valid, evt_id);
        end
      end
      if (k == 15) begin
        checks++; if (ovf !== 3'b000) begin errors++; $display("FAIL sat_ovf16 got=%b exp=000", ovf); end
      end
      if (k == 16) begin
        checks++; if (ovf !== 3'b001) begin errors++; $display("FAIL sat_ovf17 got=%b exp=001", ovf); end
      end
`endif
    end
    for (int c = 0; c < 60; c++) tick(3'b000, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_log.size() != m_log.size()) begin errors++; $display("FAIL sat_model_count got=%0d exp=%0d", d_log.size(), m_log.size()); end
`ifndef EVT_TIMEOUT_EN
    checks++;
    if (d_log.size() != 16) begin errors++; $display("FAIL sat_count got=%0d exp=16", d_log.size()); end
    foreach (d_log[k]) begin
      checks++;
      if (d_log[k] != 0) begin errors++; $display("FAIL sat_id idx=%0d got=%0d exp=0", k, d_log[k]); end
    end
`endif
    tick(3'b000, 1'b0, 1'b1, 1'b0);
    checks++; if (ovf !== 3'b000) begin errors++; $display("FAIL sat_ovf_clr got=%b exp=000", ovf); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(3'b001, 1'b0, 1'b0, 1'b0);
    tick(3'b000, 1'b0, 1'b0, 1'b0);
    tick(3'b000, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < HOLD; c++) tick((c == 2) ? 3'b110 : 3'b000, 1'b0, 1'b0, 1'b0);
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL rmid_held got=%b exp=1", evt_valid); end
    tick(3'b000, 1'b0, 1'b0, 1'b1);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", evt_valid); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL rmid_pending got=%b exp=000", pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    for (int c = 0; c < 10; c++) begin
      tick(3'b000, 1'b1, 1'b0, 1'b0);
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rmid_after cyc=%0d got=%b exp=0", c, evt_valid); end
    end
    checks++; if (d_log.size() != 0) begin errors++; $display("FAIL rmid_events got=%0d exp=0", d_log.size()); end
  endtask

`ifdef EVT_TIMEOUT_EN
  task automatic test_timeout();
    int drops;
    do_reset();
    drops = 0;
    tick(3'b100, 1'b0, 1'b0, 1'b0);
    tick(3'b000, 1'b0, 1'b0, 1'b0);
    tick(3'b000, 1'b0, 1'b0, 1'b0);
    checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin errors++; $display("FAIL to_present got valid=%b id=%0d exp 1/2", evt_valid, evt_id); end
    for (int c = 1; c <= TO + 3; c++) begin
      tick(3'b000, 1'b0, 1'b0, 1'b0);
      if (evt_drop === 1'b1) drops++;
      checks++;
      if (evt_valid !== (c < TO)) begin errors++; $display("FAIL to_valid cyc=%0d got=%b exp=%b", c, evt_valid, c < TO); end
    end
    checks++; if (drops != 1) begin errors++; $display("FAIL to_drop_pulses got=%0d exp=1", drops); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL to_pending got=%b exp=000", pending); end
    tick(3'b100, 1'b0, 1'b0, 1'b0);
    tick(3'b000, 1'b0, 1'b0, 1'b0);
    tick(3'b000, 1'b0, 1'b0, 1'b0);
    drops = 0;
    for (int c = 1; c <= TO + 3; c++) begin
      tick(3'b000, (c == TO), 1'b0, 1'b0);
      if (evt_drop === 1'b1) drops++;
    end
    checks++; if (drops != 0) begin errors++; $display("FAIL to_accept_drop got=%0d exp=0", drops); end
    checks++; if (d_log.size() != 1) begin errors++; $display("FAIL to_accept_count got=%0d exp=1", d_log.size()); end
  endtask
`else
  task automatic test_hold();
    do_reset();
    tick(3'b100, 1'b0, 1'b0, 1'b0);
    tick(3'b000, 1'b0, 1'b0, 1'b0);
    tick(3'b000, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      tick(3'b000, 1'b0, 1'b0, 1'b0);
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_drop !== 1'b0) begin
        errors++; $display("FAIL hold cyc=%0d got valid=%b id=%0d drop=%b exp 1/2/0", c, evt_valid, evt_id, evt_drop);
      end
    end
    tick(3'b000, 1'b1, 1'b0, 1'b0);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL hold_accept got=%b exp=0", evt_valid); end
    checks++; if (d_log.size() != 1) begin errors++; $display("FAIL hold_count got=%0d exp=1", d_log.size()); end
  endtask
`endif

  task automatic test_random();
    logic [2:0] p;
    logic       r, c, rs;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      p  = 3'($urandom) & 3'($urandom);
      r  = 1'($urandom);
      c  = ($urandom_range(19) == 0);
      rs = ($urandom_range(149) == 0);
      tick(p, r, c, rs);
      checks++;
      if (evt_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, evt_valid, m_valid); end
      if (m_valid) begin
        checks++;
        if (evt_id !== 2'(m_id)) begin errors++; $display("FAIL rnd_id cyc=%0d got=%0d exp=%0d", cyc, evt_id, m_id); end
      end
      checks++;
      if (pending !== m_pending_vec()) begin errors++; $display("FAIL rnd_pending cyc=%0d got=%b exp=%b", cyc, pending, m_pending_vec()); end
      checks++;
      if (ovf !== m_ovf_vec()) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", cyc, ovf, m_ovf_vec()); end
      checks++;
      if (busy !== (m_valid | m_armed)) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, m_valid | m_armed); end
      checks++;
      if (evt_drop !== m_drop) begin errors++; $display("FAIL rnd_drop cyc=%0d got=%b exp=%b", cyc, evt_drop, m_drop); end
    end
    checks++;
    if (d_log.size() != m_log.size()) begin errors++; $display("FAIL rnd_event_count got=%0d exp=%0d", d_log.size(), m_log.size()); end
    for (int k = 0; k < d_log.size() && k < m_log.size(); k++) begin
      checks++;
      if (d_log[k] != m_log[k]) begin errors++; $display("FAIL rnd_event idx=%0d got=%0d exp=%0d", k, d_log[k], m_log[k]); end
    end
  endtask

  initial begin
    rst = 1'b1; press = '0; ovf_clr = 1'b0; evt_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_press();
    test_all_keys();
    test_burst_order();
    test_saturation();
    test_reset_mid();
`ifdef EVT_TIMEOUT_EN
    test_timeout();
`else
    test_hold();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
